hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//  Pipeline sequencing controller for the 5-stage core; sits beside the operand-forwarding logic in ID/EX.
//  Resolves the hazards forwarding cannot cover: load-use stalls, taken-branch flushes and multi-cycle
//  data-memory waits. Drives the per-stage register write enables and bubble/flush controls.
//  Keeps saturating performance counters and a sticky memory-timeout error.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles of IF/ID flush after a taken branch (>=1)
//  MEM_TIMEOUT   64  max consecutive mem_busy cycles before the ERROR state (>=2)
//  CNT_W         16  width of the performance counters
// PORTS
//  clk            in   1      single core clock; all state updates on rising edge
//  reset          in   1      synchronous, active-high
//  id_rs          in   5      rs of the instruction in ID
//  id_rt          in   5      rt of the instruction in ID
//  id_uses_rt     in   1      ID instruction reads rt as a source
//  ex_memread     in   1      instruction in EX is a load
//  ex_rd          in   5      destination register of the EX instruction
//  branch_taken   in   1      branch/jump resolved taken in EX this cycle
//  mem_busy       in   1      data memory not ready; the MEM stage must hold
//  pc_write       out  1      PC update enable
//  ifid_write     out  1      IF/ID register write enable
//  ifid_flush     out  1      clear IF/ID to NOP
//  idex_write     out  1      ID/EX register write enable
//  idex_bubble    out  1      load NOP into ID/EX (controls zeroed)
//  exmem_write    out  1      EX/MEM register write enable
//  memwb_write    out  1      MEM/WB register write enable
//  mem_error      out  1      sticky memory-timeout flag
//  stall_cnt      out  CNT_W  load-use plus mem-wait stall cycles, saturating
//  flush_cnt      out  CNT_W  flush cycles, saturating
// BEHAVIOUR
//  - Outputs are combinational from state, counters and current inputs (Mealy); state updates on clk.
//  - Reset (sampled on the edge) sets state=RUN, wait_cnt=0, flush_left=0, counters=0, mem_error=0.
//  - While reset is high, all *_write outputs are 0 and flush/bubble are 0.
//  - Default (no hazard): every *_write=1; flush=0; bubble=0.
//  - load_use = ex_memread && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
//  - Priority within a cycle: reset > ERROR > mem_busy > branch_taken > load_use.
//  - RUN:
//    - mem_busy: freeze, i.e. all *_write=0, flush=0, bubble=0. Go to MEM_WAIT with wait_cnt=1. stall_cnt++.
//    - branch_taken: pc_write=1, ifid_flush=1, idex_bubble=1, flush_cnt++.
//      - FLUSH_CYCLES>1: go to FLUSH with flush_left=FLUSH_CYCLES-1.
//    - load_use: pc_write=0, ifid_write=0, idex_bubble=1, others=1. stall_cnt++. Stay in RUN.
//      - Zero-latency: asserted in the same cycle the hazard is visible.
//  - MEM_WAIT:
//    - mem_busy=1: freeze, wait_cnt++, stall_cnt++.
//      - If wait_cnt==MEM_TIMEOUT-1 on this edge, go to ERROR. Exactly MEM_TIMEOUT busy cycles total are tolerated.
//    - mem_busy=0: outputs and next state are evaluated exactly as RUN this cycle; wait_cnt=0.
//  - FLUSH:
//    - pc_write=1, ifid_flush=1, idex_bubble=1, flush_cnt++, flush_left--.
//      - Return to RUN when flush_left==1 on this edge.
//    - mem_busy overrides: freeze, flush_left held, stay in FLUSH, stall_cnt++.
//    - branch_taken in FLUSH: reload flush_left=FLUSH_CYCLES-1. The new branch wins.
//  - ERROR: all *_write=0, mem_error=1. Held until reset; counters frozen.
//  - Counters saturate at all-ones; never wrap.
//  - Reset mid-MEM_WAIT or mid-FLUSH: abandon the sequence and return to RUN on the next edge.
// TESTING
//  - Load-use: ex_memread=1, ex_rd=5, id_rs=5 -> that cycle pc_write=0, ifid_write=0, idex_bubble=1;
//    next cycle (ex_memread=0) all writes=1; stall_cnt=1.
//  - Load-use filtering:
//    - ex_rd=0 with matching id_rs=0 -> no stall.
//    - id_rt=5, id_uses_rt=0 -> no stall.
//  - Branch, FLUSH_CYCLES=2: branch_taken pulse -> ifid_flush=1 for 2 consecutive cycles, pc_write=1 both;
//    flush_cnt=2; state back in RUN.
//  - Mem wait: mem_busy high 3 cycles -> all writes 0 for 3 cycles, 1 on the 4th; stall_cnt=3; mem_error=0.
//  - Timeout, MEM_TIMEOUT=4: mem_busy held 10 cycles -> mem_error=1 after the 4th busy cycle;
//    stays 1 with mem_busy dropped; cleared only by reset.
//  - Simultaneous + reset: mem_busy=1 and branch_taken=1 -> freeze wins, no flush.
//    Reset during FLUSH -> next cycle RUN, counters 0.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: resolves load-use stalls, taken-branch
// flushes and data-memory waits, drives per-stage write/bubble/flush
// controls, and keeps saturating stall/flush counters plus a sticky
// memory-timeout error.
module hazard_stall_controller #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             memwb_write,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT) + 1;
    localparam int unsigned FLUSH_W = $clog2(FLUSH_CYCLES) + 1;

    localparam logic [WAIT_W-1:0]  WAIT_LAST   = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0]  WAIT_ONE    = WAIT_W'(1);
    localparam logic [FLUSH_W-1:0] FLUSH_RELOAD = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_ONE   = FLUSH_W'(1);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        FLUSH,
        ERROR
    } state_t;

    state_t             state, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [FLUSH_W-1:0] flush_left, flush_left_nxt;
    logic               stall_inc, flush_inc;
    logic               load_use;

    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    // Error flag is simply the ERROR state, which only reset leaves.
    assign mem_error = (state == ERROR);

    // State, sequencing counters and saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            wait_cnt   <= '0;
            flush_left <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            flush_left <= flush_left_nxt;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Next-state and Mealy output decode; priority ERROR > mem_busy > branch > load-use.
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        flush_left_nxt = flush_left;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        idex_write     = 1'b1;
        exmem_write    = 1'b1;
        memwb_write    = 1'b1;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;

        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
        end else begin
            case (state)
                ERROR: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_write = 1'b0;
                    memwb_write = 1'b0;
                end

                FLUSH: begin
                    if (mem_busy) begin
                        // Freeze holds flush_left; no timeout tracking inside FLUSH.
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_write = 1'b0;
                        memwb_write = 1'b0;
                        stall_inc   = 1'b1;
                    end else begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        flush_inc   = 1'b1;
                        if (branch_taken) begin
                            flush_left_nxt = FLUSH_RELOAD;
                        end else if (flush_left == FLUSH_ONE) begin
                            flush_left_nxt = '0;
                            state_nxt      = RUN;
                        end else begin
                            flush_left_nxt = flush_left - 1'b1;
                        end
                    end
                end

                // RUN, and MEM_WAIT once memory is ready, share one decode.
                default: begin
                    if (mem_busy) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_write = 1'b0;
                        memwb_write = 1'b0;
                        stall_inc   = 1'b1;
                        if (state == MEM_WAIT) begin
                            wait_cnt_nxt = wait_cnt + 1'b1;
                            if (wait_cnt == WAIT_LAST)
                                state_nxt = ERROR;
                        end else begin
                            wait_cnt_nxt = WAIT_ONE;
                            state_nxt    = MEM_WAIT;
                        end
                    end else begin
                        wait_cnt_nxt = '0;
                        state_nxt    = RUN;
                        if (branch_taken) begin
                            ifid_flush  = 1'b1;
                            idex_bubble = 1'b1;
                            flush_inc   = 1'b1;
                            if (FLUSH_CYCLES > 1) begin
                                flush_left_nxt = FLUSH_RELOAD;
                                state_nxt      = FLUSH;
                            end
                        end else if (load_use) begin
                            pc_write    = 1'b0;
                            ifid_write  = 1'b0;
                            idex_bubble = 1'b1;
                            stall_inc   = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: load-use, filtering, branch
// flush, memory wait, timeout error, priority, reset and counter saturation.
module tb_hazard_stall_controller;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, ex_memread, branch_taken, mem_busy;
    logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic        exmem_write, memwb_write, mem_error;
    logic [15:0] stall_cnt, flush_cnt;

    // Narrow-counter instance used only for saturation.
    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_write, s_idex_bubble;
    logic        s_exmem_write, s_memwb_write, s_mem_error;
    logic [1:0]  s_stall_cnt, s_flush_cnt;
    logic        s_memread;

    logic [4:0]  wr;
    assign wr = {pc_write, ifid_write, idex_write, exmem_write, memwb_write};

    int total = 0;
    int bad   = 0;

    hazard_stall_controller #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
        .memwb_write(memwb_write), .mem_error(mem_error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_stall_controller #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .id_rs(5'd7), .id_rt(5'd0), .id_uses_rt(1'b0),
        .ex_memread(s_memread), .ex_rd(5'd7), .branch_taken(1'b0), .mem_busy(1'b0),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .idex_write(s_idex_write), .idex_bubble(s_idex_bubble), .exmem_write(s_exmem_write),
        .memwb_write(s_memwb_write), .mem_error(s_mem_error), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle while still before the next edge.
    task automatic settle();
        #3;
    endtask

    initial begin
        reset = 1'b1; id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0; s_memread = 1'b0;

        // Reset behaviour
        #4;
        chk("rst_writes", 32'(wr), 32'h00);
        chk("rst_flush", 32'(ifid_flush), 32'h0);
        chk("rst_bubble", 32'(idex_bubble), 32'h0);
        tick();
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
        chk("rst_mem_error", 32'(mem_error), 32'h0);
        reset = 1'b0;
        s_memread = 1'b1;
        settle();
        chk("idle_writes", 32'(wr), 32'h1F);
        tick();

        // Load-use on rs
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        settle();
        chk("lu_writes", 32'(wr), 32'h07);
        chk("lu_bubble", 32'(idex_bubble), 32'h1);
        chk("lu_flush", 32'(ifid_flush), 32'h0);
        tick();
        ex_memread = 1'b0;
        settle();
        chk("lu_after_writes", 32'(wr), 32'h1F);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        tick();

        // Filtering: rd=0
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        settle();
        chk("rd0_writes", 32'(wr), 32'h1F);
        chk("rd0_bubble", 32'(idex_bubble), 32'h0);
        tick();
        chk("rd0_stall_cnt", 32'(stall_cnt), 32'd1);

        // Filtering: rt match without use, then with use
        ex_rd = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
        settle();
        chk("rt_nouse_writes", 32'(wr), 32'h1F);
        tick();
        id_uses_rt = 1'b1;
        settle();
        chk("rt_use_writes", 32'(wr), 32'h07);
        tick();
        ex_memread = 1'b0; id_uses_rt = 1'b0;
        chk("rt_use_stall_cnt", 32'(stall_cnt), 32'd2);

        // Branch flush, two cycles
        branch_taken = 1'b1;
        settle();
        chk("br1_writes", 32'(wr), 32'h1F);
        chk("br1_flush", 32'(ifid_flush), 32'h1);
        chk("br1_bubble", 32'(idex_bubble), 32'h1);
        tick();
        branch_taken = 1'b0;
        settle();
        chk("br2_flush", 32'(ifid_flush), 32'h1);
        chk("br2_pc_write", 32'(pc_write), 32'h1);
        tick();
        settle();
        chk("br_done_flush", 32'(ifid_flush), 32'h0);
        chk("br_done_writes", 32'(wr), 32'h1F);
        chk("br_flush_cnt", 32'(flush_cnt), 32'd2);
        tick();

        // Memory wait, three busy cycles
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mw_writes", 32'(wr), 32'h00);
            tick();
        end
        mem_busy = 1'b0;
        settle();
        chk("mw_release_writes", 32'(wr), 32'h1F);
        chk("mw_stall_cnt", 32'(stall_cnt), 32'd5);
        chk("mw_mem_error", 32'(mem_error), 32'h0);
        chk("sat_stall_cnt", 32'(s_stall_cnt), 32'h3);
        tick();

        // mem_busy and branch together: freeze wins
        mem_busy = 1'b1; branch_taken = 1'b1;
        settle();
        chk("prio_writes", 32'(wr), 32'h00);
        chk("prio_flush", 32'(ifid_flush), 32'h0);
        tick();
        mem_busy = 1'b0; branch_taken = 1'b0;
        settle();
        chk("prio_release_writes", 32'(wr), 32'h1F);
        chk("prio_release_flush", 32'(ifid_flush), 32'h0);
        chk("prio_flush_cnt", 32'(flush_cnt), 32'd2);
        chk("prio_stall_cnt", 32'(stall_cnt), 32'd6);
        tick();

        // Reset in the middle of FLUSH
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0; reset = 1'b1;
        settle();
        chk("rstfl_writes", 32'(wr), 32'h00);
        chk("rstfl_flush", 32'(ifid_flush), 32'h0);
        tick();
        reset = 1'b0;
        settle();
        chk("rstfl_run_flush", 32'(ifid_flush), 32'h0);
        chk("rstfl_run_writes", 32'(wr), 32'h1F);
        chk("rstfl_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rstfl_stall_cnt", 32'(stall_cnt), 32'd0);
        tick();

        // mem_busy inside FLUSH holds the flush sequence
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0; mem_busy = 1'b1;
        settle();
        chk("flbusy_writes", 32'(wr), 32'h00);
        chk("flbusy_flush", 32'(ifid_flush), 32'h0);
        tick();
        mem_busy = 1'b0;
        settle();
        chk("flresume_flush", 32'(ifid_flush), 32'h1);
        tick();
        settle();
        chk("flend_flush", 32'(ifid_flush), 32'h0);
        chk("flend_flush_cnt", 32'(flush_cnt), 32'd2);
        chk("flend_stall_cnt", 32'(stall_cnt), 32'd1);
        tick();

        // Timeout with MEM_TIMEOUT=4
        mem_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (i < 4) begin
                chk("to_early_error", 32'(mem_error), 32'h0);
                chk("to_early_writes", 32'(wr), 32'h00);
            end else begin
                chk("to_late_error", 32'(mem_error), 32'h1);
            end
            tick();
        end
        chk("to_stall_cnt", 32'(stall_cnt), 32'd5);
        mem_busy = 1'b0;
        settle();
        chk("to_held_error", 32'(mem_error), 32'h1);
        chk("to_held_writes", 32'(wr), 32'h00);
        tick();
        chk("to_frozen_stall_cnt", 32'(stall_cnt), 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("to_cleared_error", 32'(mem_error), 32'h0);
        chk("to_cleared_writes", 32'(wr), 32'h1F);
        chk("to_cleared_stall_cnt", 32'(stall_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
